// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store controller.
// Size codes, FSM states and the alignment check.
package lsu_mem_ctrl_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } lsu_state_t;

    // Illegal size or address not aligned to the access size.
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] addr_lo
    );
        case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = addr_lo[0];
            SZ_W:    misaligned = |addr_lo;
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core-side request/response handshake bundle.
// master = core, slave = load/store controller.
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_size,
        output req_unsigned, req_addr, req_wdata,
        output resp_ready,
        input  req_ready, resp_valid,
        input  resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size,
        input  req_unsigned, req_addr, req_wdata,
        input  resp_ready,
        output req_ready, resp_valid,
        output resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_lane_mux.sv
// Byte-lane extract/extend for loads and
// lane merge for sub-word stores.
module lsu_lane_mux
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]  b;
    logic [15:0] h;
    logic        sb;
    logic        sh;

    // Lane select, extension and store merge.
    always_comb begin
        b      = word[{addr_lo, 3'b000} +: 8];
        h      = word[{addr_lo[1], 4'b0000} +: 16];
        sb     = b[7] & ~uns;
        sh     = h[15] & ~uns;
        rdata  = word;
        merged = wdata;
        case (size)
            SZ_B: begin
                rdata  = {{24{sb}}, b};
                merged = word;
                merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_H: begin
                rdata  = {{16{sh}}, h};
                merged = word;
                merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller into a 1R1W word memory.
// Sub-word stores are done as read-modify-write.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = $clog2(DEPTH) + 2
) (
    input  logic              clk,
    input  logic              rst,
    lsu_mem_ctrl_if.slave     bus,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_dout,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_din,
    output logic              mem_we
);

    localparam logic [ADDR_W-3:0] IDX_MASK =
        (ADDR_W-2)'(DEPTH - 1);

    lsu_state_t        state;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [1:0]        r_lo;
    logic [31:0]       r_wdata;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       ext;
    logic [31:0]       merged;

    assign word_addr = {bus.req_addr[ADDR_W-1:2] & IDX_MASK, 2'b00};

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    lsu_lane_mux u_lane (
        .word    (mem_rd_dout),
        .addr_lo (r_lo),
        .size    (r_size),
        .uns     (r_uns),
        .wdata   (r_wdata),
        .rdata   (ext),
        .merged  (merged)
    );

    // Request FSM with registered response and memory-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            r_we        <= 1'b0;
            r_size      <= SZ_B;
            r_uns       <= 1'b0;
            r_lo        <= 2'b00;
            r_wdata     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr_addr <= '0;
            mem_wr_din  <= '0;
            mem_we      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_we    <= bus.req_we;
                        r_size  <= bus.req_size;
                        r_uns   <= bus.req_unsigned;
                        r_lo    <= bus.req_addr[1:0];
                        r_wdata <= bus.req_wdata;
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        if (misaligned(bus.req_size, bus.req_addr[1:0])) begin
                            err_q <= 1'b1;
                            state <= ST_RESP;
                        end else if (bus.req_we && bus.req_size == SZ_W) begin
                            mem_wr_addr <= word_addr;
                            mem_wr_din  <= bus.req_wdata;
                            mem_we      <= 1'b1;
                            state       <= ST_WRITE;
                        end else begin
                            mem_rd_addr <= word_addr;
                            state       <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (r_we) begin
                        mem_wr_addr <= mem_rd_addr;
                        mem_wr_din  <= merged;
                        mem_we      <= 1'b1;
                        state       <= ST_WRITE;
                    end else begin
                        rdata_q <= ext;
                        state   <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    mem_we <= 1'b0;
                    state  <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.resp_ready) state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a 4-word
// behavioural 1R1W memory.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  mem_rd_addr;
    logic [31:0] mem_rd_dout;
    logic [3:0]  mem_wr_addr;
    logic [31:0] mem_wr_din;
    logic        mem_we;
    logic [31:0] mem [4];

    int n_vec = 0;
    int n_err = 0;

    lsu_mem_ctrl_if #(.ADDR_W(4)) bus ();

    lsu_mem_ctrl #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_dout (mem_rd_dout),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_din  (mem_wr_din),
        .mem_we      (mem_we)
    );

    always #5 clk = ~clk;

    assign mem_rd_dout = mem[mem_rd_addr[3:2]];

    always @(posedge clk)
        if (mem_we) mem[mem_wr_addr[3:2]] <= mem_wr_din;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [3:0] addr,
                         input logic [31:0] wd);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic collect(output int lat, output int we_cnt,
                           output int we_cyc,
                           output logic [31:0] rd,
                           output logic er);
        lat = -1; we_cnt = 0; we_cyc = -1;
        rd = '0; er = 1'b0;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge clk);
            if (mem_we) begin
                we_cnt++;
                we_cyc = c;
            end
            if (bus.resp_valid) begin
                lat = c;
                rd  = bus.resp_rdata;
                er  = bus.resp_err;
            end
        end
    endtask

    task automatic run_req(input string tag,
                           input logic we, input logic [1:0] sz,
                           input logic uns, input logic [3:0] addr,
                           input logic [31:0] wd,
                           input int exp_lat,
                           input logic [31:0] exp_rd,
                           input logic exp_er,
                           input int exp_we_cyc);
        int lat, wc, wcy;
        logic [31:0] rd;
        logic er;
        issue(we, sz, uns, addr, wd);
        collect(lat, wc, wcy, rd, er);
        chk({tag, " lat"}, lat, exp_lat);
        chk({tag, " rdata"}, rd, exp_rd);
        chk({tag, " err"}, {31'd0, er}, {31'd0, exp_er});
        chk({tag, " we_cnt"}, wc, (exp_we_cyc > 0) ? 1 : 0);
        chk({tag, " we_cyc"}, wcy, exp_we_cyc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, wc, wcy;
        logic [31:0] rd;
        logic er;

        mem[0] = 32'h8070_F0FF;
        mem[1] = 32'h0000_0000;
        mem[2] = 32'h1122_3344;
        mem[3] = 32'h0000_0000;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.resp_ready   = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst rdata", bus.resp_rdata, 32'd0);
        rst = 1'b0;

        run_req("LB@1", 0, 2'b00, 0, 4'h1, 0, 2, 32'hFFFF_FFF0, 0, -1);
        run_req("LBU@1", 0, 2'b00, 1, 4'h1, 0, 2, 32'h0000_00F0, 0, -1);
        run_req("LH@2", 0, 2'b01, 0, 4'h2, 0, 2, 32'hFFFF_8070, 0, -1);
        run_req("LHU@2", 0, 2'b01, 1, 4'h2, 0, 2, 32'h0000_8070, 0, -1);
        run_req("LB@0", 0, 2'b00, 0, 4'h0, 0, 2, 32'hFFFF_FFFF, 0, -1);

        run_req("SW@4", 1, 2'b10, 0, 4'h4, 32'hDEAD_BEEF, 2, 0, 0, 1);
        chk("mem1 after SW", mem[1], 32'hDEAD_BEEF);
        run_req("LW@4", 0, 2'b10, 1, 4'h4, 0, 2, 32'hDEAD_BEEF, 0, -1);

        run_req("SB@A", 1, 2'b00, 0, 4'hA, 32'h0000_00AB, 3, 0, 0, 2);
        chk("mem2 after SB", mem[2], 32'h11AB_3344);
        run_req("SH@8", 1, 2'b01, 0, 4'h8, 32'h0000_CAFE, 3, 0, 0, 2);
        chk("mem2 after SH", mem[2], 32'h11AB_CAFE);

        run_req("LW@2", 0, 2'b10, 0, 4'h2, 0, 1, 0, 1, -1);
        run_req("SH@3", 1, 2'b01, 0, 4'h3, 32'h1234, 1, 0, 1, -1);
        run_req("SZ11", 1, 2'b11, 0, 4'h0, 32'h5555_5555, 1, 0, 1, -1);
        chk("mem0 after errs", mem[0], 32'h8070_F0FF);
        chk("mem1 after errs", mem[1], 32'hDEAD_BEEF);

        bus.resp_ready = 1'b0;
        issue(0, 2'b10, 0, 4'h4, 0);
        collect(lat, wc, wcy, rd, er);
        chk("hold lat", lat, 2);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b1;
        bus.req_addr     = 4'h1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold valid", {31'd0, bus.resp_valid}, 32'd1);
            chk("hold rdata", bus.resp_rdata, 32'hDEAD_BEEF);
            chk("hold ready", {31'd0, bus.req_ready}, 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("post hs ready", {31'd0, bus.req_ready}, 32'd1);
        chk("post hs valid", {31'd0, bus.resp_valid}, 32'd0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        collect(lat, wc, wcy, rd, er);
        chk("queued lat", lat, 2);
        chk("queued rdata", rd, 32'h0000_00F0);
        @(posedge clk);
        #1;

        issue(1, 2'b00, 0, 4'h9, 32'h0000_0055);
        @(negedge clk);
        chk("rmw read addr", {28'd0, mem_rd_addr}, 32'd8);
        chk("rmw in read", {31'd0, bus.req_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst ready", {31'd0, bus.req_ready}, 32'd1);
        chk("mrst valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("mrst err", {31'd0, bus.resp_err}, 32'd0);
        chk("mrst rdata", bus.resp_rdata, 32'd0);
        chk("mrst mem_we", {31'd0, mem_we}, 32'd0);
        chk("mrst rd_addr", {28'd0, mem_rd_addr}, 32'd0);
        chk("mrst wr_addr", {28'd0, mem_wr_addr}, 32'd0);
        chk("mrst wr_din", mem_wr_din, 32'd0);
        repeat (3) @(negedge clk);
        chk("mrst mem2", mem[2], 32'h11AB_CAFE);
        run_req("LW@8", 0, 2'b10, 0, 4'h8, 0, 2, 32'h11AB_CAFE, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
